// File: rtl/voice_allocator.sv
// Polyphony controller for the 24-output voice demux.
// Note events arrive over valid/ready. A sequential scan over the voice table
// picks a target, which is written to the demux in one registered WRITE cycle.
// Panic drives the demux clear-all select for one cycle.
module voice_allocator #(
  parameter int NUM_VOICES = 24,
  parameter int AGE_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_key,
  input  logic                  panic,
  output logic [7:0]            dmx_in,
  output logic [4:0]            dmx_sel,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  steal
);

  localparam logic [4:0] LAST_IDX  = 5'(NUM_VOICES - 1);
  localparam logic [4:0] CLEAR_SEL = 5'd31;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              idx_q, idx_d;
  logic                    on_q, on_d;
  logic [6:0]              key_q, key_d;
  logic                    match_found_q, match_found_d;
  logic [4:0]              match_idx_q, match_idx_d;
  logic                    free_found_q, free_found_d;
  logic [4:0]              free_idx_q, free_idx_d;
  logic                    old_found_q, old_found_d;
  logic [4:0]              old_idx_q, old_idx_d;
  logic [AGE_W-1:0]        old_age_q, old_age_d;
  logic [6:0]              vkey_q [NUM_VOICES];
  logic [6:0]              vkey_d [NUM_VOICES];
  logic [AGE_W-1:0]        vage_q [NUM_VOICES];
  logic [AGE_W-1:0]        vage_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_q, active_d;
  logic [4:0]              dmx_sel_q, dmx_sel_d;
  logic [7:0]              dmx_in_q, dmx_in_d;
  logic                    steal_q, steal_d;

  // Trackers after folding in the voice at idx_q (needed so voice 23 counts in the final decision)
  logic                    cm_found, cf_found, co_found;
  logic [4:0]              cm_idx, cf_idx, co_idx, target;
  logic [AGE_W-1:0]        co_age;
  logic                    cur_active, cur_same;

  assign dmx_in       = dmx_in_q;
  assign dmx_sel      = dmx_sel_q;
  assign voice_active = active_q;
  assign steal        = steal_q;

  // Next-state, scan tracking, table update and registered demux outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    on_d          = on_q;
    key_d         = key_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    vkey_d        = vkey_q;
    vage_d        = vage_q;
    active_d      = active_q;
    dmx_sel_d     = dmx_sel_q;
    dmx_in_d      = dmx_in_q;
    steal_d       = 1'b0;
    ev_ready      = 1'b0;
    target        = '0;

    cur_active = active_q[idx_q];
    cur_same   = (vkey_q[idx_q] == key_q);
    cm_found   = match_found_q;
    cm_idx     = match_idx_q;
    cf_found   = free_found_q;
    cf_idx     = free_idx_q;
    co_found   = old_found_q;
    co_idx     = old_idx_q;
    co_age     = old_age_q;
    if (!match_found_q && cur_active && cur_same) begin
      cm_found = 1'b1;
      cm_idx   = idx_q;
    end
    if (on_q && !free_found_q && !cur_active) begin
      cf_found = 1'b1;
      cf_idx   = idx_q;
    end
    // Strict compare keeps the lowest index on equal ages
    if (on_q && cur_active && (!old_found_q || (vage_q[idx_q] > old_age_q))) begin
      co_found = 1'b1;
      co_idx   = idx_q;
      co_age   = vage_q[idx_q];
    end

    case (state_q)
      IDLE: begin
        ev_ready = !panic;
        if (!panic && ev_valid) begin
          on_d          = ev_on;
          key_d         = ev_key;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          match_idx_d   = '0;
          free_idx_d    = '0;
          old_idx_d     = '0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        match_found_d = cm_found;
        match_idx_d   = cm_idx;
        free_found_d  = cf_found;
        free_idx_d    = cf_idx;
        old_found_d   = co_found;
        old_idx_d     = co_idx;
        old_age_d     = co_age;
        if (idx_q == LAST_IDX) begin
          state_d = WRITE;
          if (on_q) begin
            if (cm_found) begin
              target = cm_idx;
            end else if (cf_found) begin
              target = cf_idx;
            end else begin
              target  = co_idx;
              steal_d = 1'b1;
            end
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
              if (5'(v) == target) begin
                vage_d[v] = '0;
              end else if (active_q[v] && (vage_q[v] != '1)) begin
                vage_d[v] = vage_q[v] + AGE_W'(1);
              end
            end
            vkey_d[target]   = key_q;
            active_d[target] = 1'b1;
            dmx_sel_d        = target;
            dmx_in_d         = {1'b1, key_q};
          end else if (cm_found) begin
            active_d[cm_idx] = 1'b0;
            dmx_sel_d        = cm_idx;
            dmx_in_d         = {1'b0, key_q};
          end
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      CLEAR: begin
        dmx_sel_d = '0;
        dmx_in_d  = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Panic overrides whatever IDLE/SCAN/WRITE computed, dropping any pending event
    if (panic && (state_q != CLEAR)) begin
      state_d   = CLEAR;
      dmx_sel_d = CLEAR_SEL;
      dmx_in_d  = '0;
      active_d  = '0;
      steal_d   = 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        vkey_d[v] = '0;
        vage_d[v] = '0;
      end
    end
  end

  // State, voice table and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      on_q          <= 1'b0;
      key_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        vage_q[v] <= '0;
      end
      active_q  <= '0;
      dmx_sel_q <= '0;
      dmx_in_q  <= '0;
      steal_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      on_q          <= on_d;
      key_q         <= key_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      vkey_q        <= vkey_d;
      vage_q        <= vage_d;
      active_q      <= active_d;
      dmx_sel_q     <= dmx_sel_d;
      dmx_in_q      <= dmx_in_d;
      steal_q       <= steal_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: table of events with expected demux writes,
// plus hand-written reset and panic sequences.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_key;
  logic        panic;
  logic [7:0]  dmx_in;
  logic [4:0]  dmx_sel;
  logic [23:0] voice_active;
  logic        steal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        on;
    logic [6:0]  key;
    logic [4:0]  sel;
    logic [7:0]  din;
    logic [23:0] act;
    logic        stl;
  } vec_t;

  vec_t vecs [30];
  vec_t sb_q [$];

  voice_allocator #(.NUM_VOICES(24), .AGE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_key       (ev_key),
    .panic        (panic),
    .dmx_in       (dmx_in),
    .dmx_sel      (dmx_sel),
    .voice_active (voice_active),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present an event and return just after the handshake edge; ok=0 if never accepted
  task automatic handshake(input logic on, input logic [6:0] key, output logic ok);
    int n;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = key;
    n = 0;
    while (ev_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (ev_ready === 1'b1);
    if (ok) @(posedge clk);
    #1;
    ev_valid = 1'b0;
    ev_key   = 7'h7f;   // key changes after the handshake must be ignored
    ev_on    = ~on;
  endtask

  task automatic send(input vec_t v, input string tag);
    logic hs_ok;
    logic busy_ok;
    vec_t e;
    handshake(v.on, v.key, hs_ok);
    if (!hs_ok) begin
      check({tag, "_handshake"}, 0, 1);
      return;
    end
    sb_q.push_back(v);
    busy_ok = 1'b1;
    repeat (24) begin
      @(negedge clk);
      if (ev_ready !== 1'b0) busy_ok = 1'b0;
    end
    @(negedge clk);   // WRITE cycle T+25
    if (ev_ready !== 1'b0) busy_ok = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_busy"}, 32'(busy_ok), 1);
    check({tag, "_sel"}, 32'(dmx_sel), 32'(e.sel));
    check({tag, "_din"}, 32'(dmx_in), 32'(e.din));
    check({tag, "_act"}, 32'(voice_active), 32'(e.act));
    check({tag, "_steal"}, 32'(steal), 32'(e.stl));
    @(negedge clk);   // T+26
    check({tag, "_ready_back"}, 32'(ev_ready), 1);
    check({tag, "_steal_pulse"}, 32'(steal), 0);
  endtask

  initial begin
    logic ok;
    vec_t v;
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0; panic = 1'b0;

    // Reset state
    #3;
    check("rst_sel", 32'(dmx_sel), 0);
    check("rst_din", 32'(dmx_in), 0);
    check("rst_act", 32'(voice_active), 0);
    check("rst_ready", 32'(ev_ready), 1);
    check("rst_steal", 32'(steal), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single note
    v = '{on: 1'b1, key: 7'd60, sel: 5'd0, din: 8'hBC, act: 24'h000001, stl: 1'b0};
    send(v, "single");

    // Async reset between edges clears outputs at once
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_din", 32'(dmx_in), 0);
    check("arst_act", 32'(voice_active), 0);
    check("arst_sel", 32'(dmx_sel), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a scan loses the event
    handshake(1'b1, 7'd50, ok);
    check("mrst_hs", 32'(ok), 1);
    repeat (5) @(negedge clk);
    check("mrst_busy", 32'(ev_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("mrst_ready", 32'(ev_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mrst_lost_act", 32'(voice_active), 0);
    check("mrst_lost_din", 32'(dmx_in), 0);

    // Event table: fill, steal, release, no-match, retrigger, reuse free
    for (int i = 0; i < 24; i++) begin
      vecs[i].on  = 1'b1;
      vecs[i].key = 7'(40 + i);
      vecs[i].sel = 5'(i);
      vecs[i].din = 8'h80 | 8'(40 + i);
      vecs[i].act = 24'((32'd1 << (i + 1)) - 1);
      vecs[i].stl = 1'b0;
    end
    vecs[24] = '{on: 1'b1, key: 7'd70, sel: 5'd0, din: 8'hC6, act: 24'hFFFFFF, stl: 1'b1};
    vecs[25] = '{on: 1'b1, key: 7'd71, sel: 5'd1, din: 8'hC7, act: 24'hFFFFFF, stl: 1'b1};
    vecs[26] = '{on: 1'b0, key: 7'd71, sel: 5'd1, din: 8'h47, act: 24'hFFFFFD, stl: 1'b0};
    vecs[27] = '{on: 1'b0, key: 7'd99, sel: 5'd1, din: 8'h47, act: 24'hFFFFFD, stl: 1'b0};
    vecs[28] = '{on: 1'b1, key: 7'd70, sel: 5'd0, din: 8'hC6, act: 24'hFFFFFD, stl: 1'b0};
    vecs[29] = '{on: 1'b1, key: 7'd80, sel: 5'd1, din: 8'hD0, act: 24'hFFFFFF, stl: 1'b0};
    for (int i = 0; i < 30; i++) begin
      send(vecs[i], $sformatf("vec%0d", i));
    end

    // Panic during scan cycle T+10
    handshake(1'b1, 7'd90, ok);
    check("pscan_hs", 32'(ok), 1);
    repeat (10) @(negedge clk);
    panic = 1'b1;
    @(posedge clk);
    #1 panic = 1'b0;
    @(negedge clk);
    check("pscan_sel31", 32'(dmx_sel), 31);
    check("pscan_din0", 32'(dmx_in), 0);
    check("pscan_act0", 32'(voice_active), 0);
    check("pscan_ready0", 32'(ev_ready), 0);
    @(negedge clk);
    check("pscan_hold_sel", 32'(dmx_sel), 0);
    check("pscan_hold_din", 32'(dmx_in), 0);
    check("pscan_ready1", 32'(ev_ready), 1);
    repeat (30) @(negedge clk);
    check("pscan_dropped_sel", 32'(dmx_sel), 0);
    check("pscan_dropped_act", 32'(voice_active), 0);

    // Table was wiped: a new note lands on voice 0
    v = '{on: 1'b1, key: 7'd5, sel: 5'd0, din: 8'h85, act: 24'h000001, stl: 1'b0};
    send(v, "post_panic");

    // Panic wins over a simultaneous event in IDLE
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd33; panic = 1'b1;
    #1;
    check("pidle_ready0", 32'(ev_ready), 0);
    @(posedge clk);
    #1 begin ev_valid = 1'b0; panic = 1'b0; end
    @(negedge clk);
    check("pidle_sel31", 32'(dmx_sel), 31);
    check("pidle_act0", 32'(voice_active), 0);
    @(negedge clk);
    check("pidle_hold_sel", 32'(dmx_sel), 0);
    check("pidle_ready1", 32'(ev_ready), 1);
    repeat (30) @(negedge clk);
    check("pidle_no_hs_act", 32'(voice_active), 0);
    check("pidle_no_hs_din", 32'(dmx_in), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
